modexp_ctrl: RTL and testbench
==============================

Name: modexp_ctrl

Overview:
- Initiator-side sequencer for the `montgomery` multiplier. It drives that block's start/operand inputs and consumes its done/result outputs.
- It computes result = X^E mod M using left-to-right binary exponentiation in the Montgomery domain.
- Sits between the host register interface and one `montgomery` instance in `hw_project`.
- Owns all operand muxing, exponent bit scanning and the one-pulse start/done handshake.

Parameters:
- WIDTH, 1024: modulus/operand width in bits; must match `montgomery`.
- E_WIDTH, 1024: exponent register width in bits.
- ELEN_W, 11: width of the exponent-length input; must satisfy 2^ELEN_W > E_WIDTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; inputs sampled this cycle
- in_x  in  WIDTH  base X, with X < M
- in_e  in  E_WIDTH  exponent
- in_e_len  in  ELEN_W  number of valid exponent bits, scanned from bit e_len-1 down to 0
- in_m  in  WIDTH  odd modulus M
- in_r  in  WIDTH  R mod M, with R = 2^WIDTH
- in_r2  in  WIDTH  R^2 mod M
- result  out  WIDTH  X^E mod M
- done  out  1  one-cycle pulse; result valid from this cycle until the next accepted start
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- mont_start  out  1  one-cycle pulse to the multiplier
- mont_a  out  WIDTH  multiplier operand A
- mont_b  out  WIDTH  multiplier operand B
- mont_m  out  WIDTH  modulus to the multiplier
- mont_done  in  1  multiplier completion pulse
- mont_result  in  WIDTH  multiplier output, valid while mont_done is high

Behaviour:
- Reset (asynchronous, active-low), while resetn is low:
  - outputs forced: result=0, done=0, busy=0, mont_start=0, mont_a=0, mont_b=0, mont_m=0;
  - state=IDLE, all internal registers cleared.
- Reset asserted mid-operation: aborts immediately. No done is emitted afterwards. A mont_done arriving after release is ignored because the FSM is in IDLE.
- Accepting start:
  - start is accepted only in IDLE.
  - On acceptance, latch x, e, m, r, r2 and len = min(in_e_len, E_WIDTH).
  - start while busy is ignored.
- Operand stability: mont_a, mont_b and mont_m are registered and held stable from the mont_start cycle until mont_done. The multiplier re-samples B and M every cycle, so this is mandatory.
- Handshake: exactly one mont_start pulse per issued operation, launched the cycle after operands are registered. mont_done is honoured only in WAIT_* states and ignored elsewhere.
- Registers: acc (WIDTH), xt (WIDTH), idx (ELEN_W), seen (1).
- FSM states and transitions:
  - IDLE -> TOMONT on accepted start.
  - TOMONT: a=x, b=r2; pulse; -> W_TOMONT.
  - W_TOMONT: on mont_done, xt=mont_result and acc=r (Montgomery one).
    - len==0 -> FROMMONT; else idx=len-1 -> SQR.
  - SQR: a=acc, b=acc; pulse; -> W_SQR.
  - W_SQR: on mont_done, acc=mont_result.
    - e[idx] -> MUL; else -> NEXT.
  - MUL: a=acc, b=xt; pulse; -> W_MUL.
  - W_MUL: on mont_done, acc=mont_result -> NEXT.
  - NEXT: idx==0 -> FROMMONT; else idx-=1 -> SQR.
  - FROMMONT: a=acc, b=1; pulse; -> W_FROM.
  - W_FROM: on mont_done, result=mont_result -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Operation count: 2 + len + popcount(e[len-1:0]) multiplier operations.
- Controller overhead: 1 cycle per state transition, in addition to multiplier latency.
- Edge cases:
  - e==0 with len>0 gives acc=R, so result=1.
  - X=0 gives result 0 unless e==0.

Optional Feature:
- Macro: MODEXP_LZ_SKIP_EN.
- Defined:
  - while seen==0, a 0 bit is skipped with no operation issued;
  - the first 1 bit sets acc=xt directly (no SQR/MUL) and sets seen=1;
  - scanning then proceeds normally;
  - if no set bit exists, the result is 1.
- Undefined: every bit costs a SQR, plus a MUL when the bit is 1.
- The result is identical in both cases; only the operation count differs.

Decomposition:
- Package modexp_pkg holds:
  - the state enum/localparams;
  - the operand-select encoding (SEL_X_R2, SEL_ACC_ACC, SEL_ACC_XT, SEL_ACC_ONE);
  - the ONE constant.
- One sub-module, modexp_opmux: registered operand-select mux plus the mont_start pulse generator.
- The FSM and bit scanner stay in modexp_ctrl.

Test Plan:
- Use a behavioural Montgomery responder with a fixed latency of 6 cycles.
- Directed scenarios:
  1. x=3, e=5, len=3, M=1000003 -> result=243. Exactly 7 mont_start pulses (5 with LZ_SKIP). One done pulse.
  2. x=2, e=0, len=4 -> result=1. 6 operations (2 with LZ_SKIP).
  3. len=0, any e -> result=1 after exactly 2 operations. busy high throughout.
  4. start re-asserted while busy, and a spurious mont_done in a SQR state -> both ignored. Result unchanged, operation count unchanged.
  5. resetn pulled low during W_MUL -> all outputs 0 immediately, no done. A later start with x=7, e=2, M=11 -> result=5.
  6. in_e_len=2047 with E_WIDTH=1024 -> clamped to 1024 bits. Result matches the model, with 1024 SQR operations.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states,
// multiplier operand-select codes and the Montgomery "leave domain" constant.
package modexp_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TOMONT   = 4'd1,
    W_TOMONT = 4'd2,
    SQR      = 4'd3,
    W_SQR    = 4'd4,
    MUL      = 4'd5,
    W_MUL    = 4'd6,
    NEXT     = 4'd7,
    FROMMONT = 4'd8,
    W_FROM   = 4'd9,
    DONE     = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    SEL_X_R2    = 2'd0,
    SEL_ACC_ACC = 2'd1,
    SEL_ACC_XT  = 2'd2,
    SEL_ACC_ONE = 2'd3
  } op_sel_e;

  // Multiplying by plain 1 strips the R factor on the way out of the domain.
  localparam int unsigned ONE = 1;

endpackage

// File: rtl/modexp_if.sv
// Start/done handshake and operand bus between the sequencer (master)
// and one Montgomery multiplier (slave).
interface modexp_if #(
  parameter int WIDTH = 1024
);
  logic             mont_start;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_m;
  logic             mont_done;
  logic [WIDTH-1:0] mont_result;

  modport master (
    output mont_start, mont_a, mont_b, mont_m,
    input  mont_done, mont_result
  );

  modport slave (
    input  mont_start, mont_a, mont_b, mont_m,
    output mont_done, mont_result
  );
endinterface

// File: rtl/modexp_opmux.sv
// Registered operand mux for the multiplier plus the one-cycle start pulse;
// operands stay frozen between issues because the multiplier re-reads B and M.
module modexp_opmux
  import modexp_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue,
  input  op_sel_e          sel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] xt,
  input  logic [WIDTH-1:0] m,
  output logic             mont_start,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m
);

  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  always_comb begin
    a_nxt = acc;
    b_nxt = acc;
    case (sel)
      SEL_X_R2: begin
        a_nxt = x;
        b_nxt = r2;
      end
      SEL_ACC_ACC: ;
      SEL_ACC_XT:  b_nxt = xt;
      SEL_ACC_ONE: b_nxt = WIDTH'(ONE);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
    end else begin
      mont_start <= issue;
      if (issue) begin
        mont_a <= a_nxt;
        mont_b <= b_nxt;
        mont_m <= m;
      end
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary X^E mod M sequencer driving one Montgomery multiplier.
// Build option MODEXP_LZ_SKIP_EN: skip leading zero exponent bits without issuing ops.
//   state    | meaning
//   IDLE     | waiting for start
//   TOMONT   | issue x*r2 (enter domain); W_TOMONT waits for it
//   SQR      | issue acc*acc; W_SQR waits
//   MUL      | issue acc*xt; W_MUL waits
//   NEXT     | step to next exponent bit or finish
//   FROMMONT | issue acc*1 (leave domain); W_FROM waits
//   DONE     | one-cycle done pulse
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH   = 1024,
  parameter int E_WIDTH = 1024,
  parameter int ELEN_W  = 11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [ELEN_W-1:0]  in_e_len,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_r2,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  modexp_if.master           mb
);

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   x_q, m_q, r_q, r2_q, acc, xt;
  logic [E_WIDTH-1:0] e_q;
  logic [ELEN_W-1:0]  len_q, idx;
  logic               ebit, issue, skip;
  op_sel_e            sel;

  assign ebit = |(e_q & (E_WIDTH'(1) << idx));

`ifdef MODEXP_LZ_SKIP_EN
  logic seen;
  assign skip = !seen;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = TOMONT;
      TOMONT:   state_nxt = W_TOMONT;
      W_TOMONT: if (mb.mont_done) state_nxt = (len_q == '0) ? FROMMONT : SQR;
      SQR:      state_nxt = skip ? NEXT : W_SQR;
      W_SQR:    if (mb.mont_done) state_nxt = ebit ? MUL : NEXT;
      MUL:      state_nxt = W_MUL;
      W_MUL:    if (mb.mont_done) state_nxt = NEXT;
      NEXT:     state_nxt = (idx == '0) ? FROMMONT : SQR;
      FROMMONT: state_nxt = W_FROM;
      W_FROM:   if (mb.mont_done) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    sel   = SEL_X_R2;
    done  = (state == DONE);
    busy  = (state != IDLE);
    case (state)
      TOMONT:   begin issue = 1'b1;  sel = SEL_X_R2;    end
      SQR:      begin issue = !skip; sel = SEL_ACC_ACC; end
      MUL:      begin issue = 1'b1;  sel = SEL_ACC_XT;  end
      FROMMONT: begin issue = 1'b1;  sel = SEL_ACC_ONE; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      r2_q   <= '0;
      e_q    <= '0;
      len_q  <= '0;
      idx    <= '0;
      acc    <= '0;
      xt     <= '0;
      result <= '0;
`ifdef MODEXP_LZ_SKIP_EN
      seen   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q   <= in_x;
          m_q   <= in_m;
          r_q   <= in_r;
          r2_q  <= in_r2;
          e_q   <= in_e;
          len_q <= (in_e_len > ELEN_W'(E_WIDTH)) ? ELEN_W'(E_WIDTH) : in_e_len;
`ifdef MODEXP_LZ_SKIP_EN
          seen  <= 1'b0;
`endif
        end
        W_TOMONT: if (mb.mont_done) begin
          xt  <= mb.mont_result;
          acc <= r_q;
          idx <= len_q - ELEN_W'(1);
        end
`ifdef MODEXP_LZ_SKIP_EN
        // First set bit: acc = x directly, since squaring/multiplying R is a no-op.
        SQR: if (!seen && ebit) begin
          acc  <= xt;
          seen <= 1'b1;
        end
`endif
        W_SQR, W_MUL: if (mb.mont_done) acc <= mb.mont_result;
        NEXT:   if (idx != '0) idx <= idx - ELEN_W'(1);
        W_FROM: if (mb.mont_done) result <= mb.mont_result;
        default: ;
      endcase
    end
  end

  modexp_opmux #(.WIDTH(WIDTH)) u_opmux (
    .clk        (clk),
    .resetn     (resetn),
    .issue      (issue),
    .sel        (sel),
    .x          (x_q),
    .r2         (r2_q),
    .acc        (acc),
    .xt         (xt),
    .m          (m_q),
    .mont_start (mb.mont_start),
    .mont_a     (mb.mont_a),
    .mont_b     (mb.mont_b),
    .mont_m     (mb.mont_m)
  );

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a 6-cycle behavioural Montgomery responder.
module tb_modexp_ctrl;
  localparam int W  = 32;
  localparam int EW = 1024;
  localparam int LW = 11;
`ifdef MODEXP_LZ_SKIP_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [W-1:0]  in_x, in_m, in_r, in_r2, result;
  logic [EW-1:0] in_e;
  logic [LW-1:0] in_e_len;
  logic          done, busy;

  modexp_if #(.WIDTH(W)) mb ();

  modexp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .ELEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e),
    .in_e_len(in_e_len), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy), .mb(mb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           ops;
    int           base;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ops_total;
  bit   spur_arm = 1'b0;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [65:0] t;
    t = {34'b0, a} * {34'b0, b};
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + {34'b0, m};
      t = t >> 1;
    end
    if (t >= {34'b0, m}) t = t - {34'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] r_of(input logic [W-1:0] m);
    logic [63:0] t;
    t = 64'h1_0000_0000 % {32'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] r2_of(input logic [W-1:0] m);
    logic [63:0] r, t;
    r = {32'b0, r_of(m)};
    t = (r * r) % {32'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] powmod(input logic [W-1:0] x, input logic [EW-1:0] e,
                                          input int len, input logic [W-1:0] m);
    logic [63:0] a;
    a = 64'd1 % {32'b0, m};
    for (int i = len - 1; i >= 0; i--) begin
      a = (a * a) % {32'b0, m};
      if (e[i]) a = (a * {32'b0, x}) % {32'b0, m};
    end
    return a[W-1:0];
  endfunction

  // Responder: a single process owns mont_done/mont_result and the op counter.
  initial begin
    logic [W-1:0] pa, pb, pm;
    int  cnt;
    bit  spur_next, spur_fired;
    cnt = 0; spur_next = 1'b0; spur_fired = 1'b0; ops_total = 0;
    pa = '0; pb = '0; pm = '0;
    mb.mont_done = 1'b0;
    mb.mont_result = '0;
    forever begin
      @(posedge clk); #1;
      mb.mont_done = 1'b0;
      if (spur_next) begin
        mb.mont_done = 1'b1;
        mb.mont_result = 32'h0005_a5a5;
        spur_next = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mb.mont_done = 1'b1;
          mb.mont_result = mont(pa, pb, pm);
          if (spur_arm && !spur_fired) begin
            spur_next = 1'b1;
            spur_fired = 1'b1;
          end
        end
      end
      if (mb.mont_start) begin
        pa = mb.mont_a; pb = mb.mont_b; pm = mb.mont_m;
        cnt = 5;
        ops_total++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t it;
    forever begin
      @(negedge clk);
      if (resetn && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          it = sb.pop_front();
          chk("result", result, it.res);
          chk("op_count", 64'(ops_total - it.base), 64'(it.ops));
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mont_start"}, mb.mont_start, 0);
    chk({tag, "_mont_a"}, mb.mont_a, 0);
    chk({tag, "_mont_b"}, mb.mont_b, 0);
    chk({tag, "_mont_m"}, mb.mont_m, 0);
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                       input logic [W-1:0] m);
    in_x = x; in_e = e; in_e_len = len[LW-1:0]; in_m = m;
    in_r = r_of(m); in_r2 = r2_of(m);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                     input logic [W-1:0] m, input logic [W-1:0] exp_res,
                     input int exp_ops, input bit poke);
    bit got, busy_ok;
    @(posedge clk); #1;
    drive(x, e, len, m);
    start = 1'b1;
    sb.push_back('{res: exp_res, ops: exp_ops, base: ops_total});
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0; busy_ok = 1'b1;
    for (int c = 0; c < 40000 && !got; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
      if (poke && c == 20) begin
        drive(32'd5, 1024'd9, 4, m);
        start = 1'b1;
      end
      if (poke && c == 21) start = 1'b0;
    end
    chk("done_seen", got, 1);
    chk("busy_window", busy_ok, 1);
  endtask

  initial begin
    logic [EW-1:0] e6;
    int  base;
    bit  reached;
    resetn = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    fork
      monitor();
    join_none
    #1 resetn = 1'b0;
    #2 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    run(32'd3, 1024'd5, 3, 32'd1000003, 32'd243, LZ ? 5 : 7, 1'b0);
    run(32'd2, 1024'd0, 4, 32'd1000003, 32'd1,   LZ ? 2 : 6, 1'b0);
    run(32'd9, 1024'd5, 0, 32'd1000003, 32'd1,   2,          1'b0);
    run(32'd0, 1024'd6, 3, 32'd1000003, 32'd0,   LZ ? 5 : 7, 1'b0);

    spur_arm = 1'b1;
    run(32'd3, 1024'd5, 3, 32'd1000003, 32'd243, LZ ? 5 : 7, 1'b1);
    spur_arm = 1'b0;

    // Abort during the first multiply step, then restart cleanly.
    @(posedge clk); #1;
    drive(32'd3, 1024'd5, 3, 32'd1000003);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = ops_total;
    reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(posedge clk); #2;
      if (ops_total - base >= (LZ ? 4 : 3)) reached = 1'b1;
    end
    chk("abort_reach_mul", reached, 1);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_zero_outputs("abort");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    run(32'd7, 1024'd2, 2, 32'd11, 32'd5, LZ ? 3 : 5, 1'b0);

    e6 = {32{32'hA5A5_0F01}};
    run(32'd12345, e6, 2047, 32'd1000003, powmod(32'd12345, e6, 1024, 32'd1000003),
        LZ ? 1440 : 1442, 1'b0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drain", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
